// File: rtl/ab_share_arbiter.sv
// ab_share_arbiter: two-way request/grant/done arbiter with a saturating signed lead balance.
// Build with GRANT_TIMEOUT_EN defined to force release after HOLD_MAX grant cycles.
module ab_share_arbiter #(
  parameter int MAX_LEAD = 3,
  parameter int HOLD_MAX = 15,
  parameter int LW = $clog2(MAX_LEAD+1)+1
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          reqA,
  input  logic          reqB,
  input  logic          doneA,
  input  logic          doneB,
  output logic          gntA,
  output logic          gntB,
  output logic          busy,
  output logic [LW-1:0] lead,
  output logic          AeqB,
  output logic          AmB,
  output logic          BmA,
  output logic          to_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic signed [LW-1:0] LeadMax = LW'(MAX_LEAD);
  localparam logic signed [LW-1:0] LeadMin = -LeadMax;

  state_t state, stateN;
  logic signed [LW-1:0] leadQ, leadN;
  logic lastA, lastAN;
  logic grantA, grantB;
  logic leadNeg, leadPos;

`ifdef GRANT_TIMEOUT_EN
  localparam int HoldW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX+1) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_MAX-1);
  logic [HoldW-1:0] holdQ, holdN;
  logic forceRel, toErrQ;
`else
  logic unusedHold;
  assign unusedHold = |HOLD_MAX;
`endif

  assign leadNeg = leadQ[LW-1];
  assign leadPos = !leadQ[LW-1] && (leadQ != '0);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      leadQ <= '0;
      lastA <= 1'b0;
    end else begin
      state <= stateN;
      leadQ <= leadN;
      lastA <= lastAN;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      holdQ  <= '0;
      toErrQ <= 1'b0;
    end else begin
      holdQ  <= holdN;
      toErrQ <= forceRel;
    end
  end
`endif

  always_comb begin
    stateN = state;
    leadN  = leadQ;
    lastAN = lastA;
    grantA = 1'b0;
    grantB = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    holdN    = holdQ + HoldW'(1);
    forceRel = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (reqA && !reqB) begin
          grantA = 1'b1;
        end else if (!reqA && reqB) begin
          grantB = 1'b1;
        end else if (reqA && reqB) begin
          // the side behind in the balance wins; on a tie, alternate
          if (leadNeg)      grantA = 1'b1;
          else if (leadPos) grantB = 1'b1;
          else if (lastA)   grantB = 1'b1;
          else              grantA = 1'b1;
        end
      end
      GNT_A: begin
        if (doneA) stateN = IDLE;
`ifdef GRANT_TIMEOUT_EN
        else if (holdQ == HoldLast) begin
          stateN   = IDLE;
          forceRel = 1'b1;
        end
`endif
      end
      GNT_B: begin
        if (doneB) stateN = IDLE;
`ifdef GRANT_TIMEOUT_EN
        else if (holdQ == HoldLast) begin
          stateN   = IDLE;
          forceRel = 1'b1;
        end
`endif
      end
      default: stateN = IDLE;
    endcase
    if (grantA) begin
      stateN = GNT_A;
      lastAN = 1'b1;
      if (leadQ != LeadMax) leadN = leadQ + LW'(1);
    end
    if (grantB) begin
      stateN = GNT_B;
      lastAN = 1'b0;
      if (leadQ != LeadMin) leadN = leadQ - LW'(1);
    end
`ifdef GRANT_TIMEOUT_EN
    if (grantA || grantB || stateN == IDLE) holdN = '0;
`endif
  end

  always_comb begin
    gntA = (state == GNT_A);
    gntB = (state == GNT_B);
    busy = (state == GNT_A) || (state == GNT_B);
    lead = leadQ;
    AeqB = (leadQ == '0);
    AmB  = leadPos;
    BmA  = leadNeg;
`ifdef GRANT_TIMEOUT_EN
    to_err = toErrQ;
`else
    to_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ab_share_arbiter.sv
// tb_ab_share_arbiter: directed and random checks of ab_share_arbiter against a
// behavioural model of the grant/lead rules.
module tb_ab_share_arbiter;

  localparam int MAX_LEAD = 3;
  localparam int HOLD_MAX = 4;
  localparam int LW = $clog2(MAX_LEAD+1)+1;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic CLK, rst_n;
  logic reqA, reqB, doneA, doneB;
  logic gntA, gntB, busy, AeqB, AmB, BmA, to_err;
  logic [LW-1:0] lead;

  int nChecks = 0;
  int nFail = 0;

  // model: owner 0=none 1=A 2=B
  int mOwner, mLead, mHeld, mToErr;
  bit mLastA;

  ab_share_arbiter #(.MAX_LEAD(MAX_LEAD), .HOLD_MAX(HOLD_MAX)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .reqA(reqA), .reqB(reqB),
    .doneA(doneA), .doneB(doneB),
    .gntA(gntA), .gntB(gntB), .busy(busy),
    .lead(lead), .AeqB(AeqB), .AmB(AmB), .BmA(BmA),
    .to_err(to_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mReset();
    mOwner = 0;
    mLead = 0;
    mHeld = 0;
    mToErr = 0;
    mLastA = 1'b0;
  endtask

  task automatic mGrant(input bit toA);
    mOwner = toA ? 1 : 2;
    mLastA = toA;
    mHeld = 0;
    if (toA) mLead = (mLead + 1 > MAX_LEAD) ? MAX_LEAD : mLead + 1;
    else     mLead = (mLead - 1 < -MAX_LEAD) ? -MAX_LEAD : mLead - 1;
  endtask

  task automatic mEdge();
    bit done;
    mToErr = 0;
    if (mOwner == 0) begin
      if (reqA && !reqB)      mGrant(1'b1);
      else if (!reqA && reqB) mGrant(1'b0);
      else if (reqA && reqB) begin
        if (mLead < 0)      mGrant(1'b1);
        else if (mLead > 0) mGrant(1'b0);
        else                mGrant(!mLastA);
      end
    end else begin
      done = (mOwner == 1) ? doneA : doneB;
      mHeld++;
      if (done) mOwner = 0;
      else if (TimeoutOn && mHeld == HOLD_MAX) begin
        mOwner = 0;
        mToErr = 1;
      end
    end
  endtask

  task automatic checkAll();
    chk("gntA", int'(gntA), int'(mOwner == 1));
    chk("gntB", int'(gntB), int'(mOwner == 2));
    chk("busy", int'(busy), int'(mOwner != 0));
    chk("lead", int'($signed(lead)), mLead);
    chk("AeqB", int'(AeqB), int'(mLead == 0));
    chk("AmB", int'(AmB), int'(mLead > 0));
    chk("BmA", int'(BmA), int'(mLead < 0));
    chk("to_err", int'(to_err), mToErr);
    chk("mutex", int'(gntA & gntB), 0);
  endtask

  task automatic drive(input bit a, input bit b, input bit da, input bit db);
    reqA = a;
    reqB = b;
    doneA = da;
    doneB = db;
  endtask

  task automatic cyc();
    @(posedge CLK);
    mEdge();
    @(negedge CLK);
    checkAll();
  endtask

  task automatic doReset();
    @(negedge CLK);
    rst_n = 1'b0;
    #1;
    mReset();
    checkAll();
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  initial begin
    int gntCyc, errCnt;
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    mReset();
    repeat (2) @(negedge CLK);
    checkAll();
    rst_n = 1'b1;
    cyc();

    // single requester A
    drive(1, 0, 0, 0); cyc();
    chk("singleA_lead", int'($signed(lead)), 1);
    chk("singleA_AmB", int'(AmB), 1);
    drive(0, 0, 0, 0); cyc(); cyc();
    drive(0, 0, 1, 0); cyc();
    chk("singleA_rel", int'(gntA), 0);
    chk("singleA_keep", int'($signed(lead)), 1);
    drive(0, 0, 0, 0); cyc();

    // tie from reset: A first, then B after one idle cycle
    doReset();
    drive(1, 1, 0, 0); cyc();
    chk("tie_firstA", int'(gntA), 1);
    drive(1, 1, 1, 0); cyc();
    chk("tie_idle", int'(busy), 0);
    drive(1, 1, 0, 0); cyc();
    chk("tie_thenB", int'(gntB), 1);
    chk("tie_AeqB", int'(AeqB), 1);
    drive(0, 0, 0, 1); cyc();

    // saturation at +MAX_LEAD
    doReset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0); cyc();
      drive(0, 0, 1, 0); cyc();
    end
    chk("sat_lead", int'($signed(lead)), MAX_LEAD);
    drive(1, 1, 0, 0); cyc();
    chk("sat_tieB", int'(gntB), 1);
    chk("sat_dec", int'($signed(lead)), MAX_LEAD - 1);
    drive(0, 0, 0, 1); cyc();

    // grant hold / timeout
    doReset();
    drive(1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0);
    gntCyc = int'(gntA);
    errCnt = 0;
    for (int i = 0; i < 49; i++) begin
      cyc();
      gntCyc += int'(gntA);
      errCnt += int'(to_err);
    end
    chk("hold_cycles", gntCyc, TimeoutOn ? HOLD_MAX : 50);
    chk("hold_err", errCnt, TimeoutOn ? 1 : 0);
    chk("hold_lead", int'($signed(lead)), 1);
    drive(0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0); cyc();

    // reset mid-grant in GNT_B
    doReset();
    drive(0, 1, 0, 0); cyc();
    drive(0, 0, 0, 0); cyc();
    chk("mid_lead", int'($signed(lead)), -1);
    @(negedge CLK);
    #2 rst_n = 1'b0;
    #1;
    mReset();
    chk("mid_gntB", int'(gntB), 0);
    chk("mid_AeqB", int'(AeqB), 1);
    checkAll();
    @(negedge CLK);
    rst_n = 1'b1;
    drive(1, 1, 0, 0); cyc();
    chk("mid_firstA", int'(gntA), 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
